iic_burst_master: RTL and testbench

Parametrised I2C master for the flight controller's sensor bus, successor to the fixed-function MPU-6050 reader. It performs either a single-register write or a variable-length burst read (repeated-start) from any 7-bit device. It supports slave clock stretching with a stall timeout and streams read bytes out one per valid pulse. The IMU and barometer front-ends sit on top of this block and issue transactions to it.

---
 rtl/iic_burst_master.sv | 256 +++++++++++++++++++++++++
 tb/tb_iic_burst_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_burst_master.sv
// rtl/iic_burst_master.sv - I2C master for single-register writes and repeated-start burst reads
// Open-drain style outputs: oe=1 pulls the line low. Each bit is four QTR-cycle phases.
module iic_burst_master #(
  parameter int CLK_MAIN       = 50_000_000,
  parameter int SCL_FREQ       = 400_000,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 10_000,
  parameter int LW             = $clog2(MAX_BURST + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_rw,
  input  logic [6:0]    i_dev_addr,
  input  logic [7:0]    i_reg_addr,
  input  logic [7:0]    i_wdata,
  input  logic [LW-1:0] i_len,
  input  logic          i_scl,
  input  logic          i_sda,
  output logic          o_scl_oe,
  output logic          o_sda_oe,
  output logic [7:0]    o_rdata,
  output logic          o_rdata_valid,
  output logic          o_rdata_last,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_nack,
  output logic          o_timeout
);

  localparam int QTR = CLK_MAIN / (4 * SCL_FREQ);
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int SW  = $clog2(TIMEOUT_CYCLES + 1);

  // Each data state is immediately followed by its ACK state (state + 1).
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_ADDR_W = 4'd2;
  localparam logic [3:0] S_ACK_A  = 4'd3;
  localparam logic [3:0] S_REG    = 4'd4;
  localparam logic [3:0] S_ACK_R  = 4'd5;
  localparam logic [3:0] S_WDATA  = 4'd6;
  localparam logic [3:0] S_ACK_D  = 4'd7;
  localparam logic [3:0] S_RSTART = 4'd8;
  localparam logic [3:0] S_ADDR_R = 4'd9;
  localparam logic [3:0] S_ACK_A2 = 4'd10;
  localparam logic [3:0] S_READ   = 4'd11;
  localparam logic [3:0] S_MACK   = 4'd12;
  localparam logic [3:0] S_STOP   = 4'd13;

  logic [3:0]    r_state;
  logic [QW-1:0] r_qcnt;
  logic [1:0]    r_phase;
  logic [2:0]    r_bit;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic [LW-1:0] r_left;
  logic          r_rw;
  logic [6:0]    r_dev;
  logic [7:0]    r_reg;
  logic [7:0]    r_wdata;
  logic [SW-1:0] r_stall;
  logic          r_busy;
  logic          r_done;
  logic          r_nack;
  logic          r_timeout;
  logic [7:0]    r_rdata;
  logic          r_rdata_valid;
  logic          r_rdata_last;

  logic w_req_ok;
  logic w_held;
  logic w_scl_oe;
  logic w_sda_oe;

  assign w_req_ok = !i_rw || ((i_len != '0) && (int'(i_len) <= MAX_BURST));
  // A slave stretching SCL keeps the released phase from advancing.
  assign w_held   = (r_state != S_IDLE) && (r_phase == 2'd2) && !i_scl;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_qcnt        <= '0;
      r_phase       <= 2'd0;
      r_bit         <= 3'd0;
      r_tx          <= 8'h00;
      r_rx          <= 8'h00;
      r_left        <= '0;
      r_rw          <= 1'b0;
      r_dev         <= 7'h00;
      r_reg         <= 8'h00;
      r_wdata       <= 8'h00;
      r_stall       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_nack        <= 1'b0;
      r_timeout     <= 1'b0;
      r_rdata       <= 8'h00;
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (i_start && w_req_ok) begin
          r_state   <= S_START;
          r_qcnt    <= '0;
          r_phase   <= 2'd0;
          r_bit     <= 3'd0;
          r_stall   <= '0;
          r_rw      <= i_rw;
          r_dev     <= i_dev_addr;
          r_reg     <= i_reg_addr;
          r_wdata   <= i_wdata;
          r_left    <= i_len;
          r_busy    <= 1'b1;
          r_nack    <= 1'b0;
          r_timeout <= 1'b0;
        end
      end else if (w_held) begin
        if (r_stall == SW'(TIMEOUT_CYCLES - 1)) begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_timeout <= 1'b1;
          r_stall   <= '0;
        end else begin
          r_stall <= r_stall + SW'(1);
        end
      end else begin
        r_stall <= '0;
        if (r_qcnt == QW'(QTR - 1)) begin
          r_qcnt  <= '0;
          r_phase <= r_phase + 2'd1;
          if (r_phase == 2'd3) begin
            case (r_state)
              S_START: begin
                r_state <= S_ADDR_W;
                r_tx    <= {r_dev, 1'b0};
                r_bit   <= 3'd0;
              end
              S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
                r_tx  <= {r_tx[6:0], 1'b0};
                r_bit <= r_bit + 3'd1;
                if (r_bit == 3'd7) r_state <= r_state + 4'd1;
              end
              S_ACK_A: begin
                if (i_sda) begin
                  r_nack  <= 1'b1;
                  r_state <= S_STOP;
                end else begin
                  r_state <= S_REG;
                  r_tx    <= r_reg;
                end
              end
              S_ACK_R: begin
                if (i_sda) begin
                  r_nack  <= 1'b1;
                  r_state <= S_STOP;
                end else if (r_rw) begin
                  r_state <= S_RSTART;
                end else begin
                  r_state <= S_WDATA;
                  r_tx    <= r_wdata;
                end
              end
              S_ACK_D: begin
                if (i_sda) r_nack <= 1'b1;
                r_state <= S_STOP;
              end
              S_RSTART: begin
                r_state <= S_ADDR_R;
                r_tx    <= {r_dev, 1'b1};
              end
              S_ACK_A2: begin
                if (i_sda) begin
                  r_nack  <= 1'b1;
                  r_state <= S_STOP;
                end else begin
                  r_state <= S_READ;
                end
              end
              S_READ: begin
                r_rx  <= {r_rx[6:0], i_sda};
                r_bit <= r_bit + 3'd1;
                if (r_bit == 3'd7) begin
                  r_rdata       <= {r_rx[6:0], i_sda};
                  r_rdata_valid <= 1'b1;
                  r_rdata_last  <= (r_left == LW'(1));
                  r_state       <= S_MACK;
                end
              end
              S_MACK: begin
                r_left  <= r_left - LW'(1);
                r_state <= (r_left == LW'(1)) ? S_STOP : S_READ;
              end
              S_STOP: begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
              default: begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            endcase
          end
        end else begin
          r_qcnt <= r_qcnt + QW'(1);
        end
      end
    end
  end

  // Line drive is decoded from registered state so a slave sees SCL release in phase 2 at once.
  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    case (r_state)
      S_START: w_sda_oe = (r_phase == 2'd3);
      S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
        w_scl_oe = ~r_phase[1];
        w_sda_oe = ~r_tx[7];
      end
      S_ACK_A, S_ACK_R, S_ACK_D, S_ACK_A2, S_READ: w_scl_oe = ~r_phase[1];
      S_MACK: begin
        w_scl_oe = ~r_phase[1];
        w_sda_oe = (r_left != LW'(1));
      end
      S_RSTART: begin
        w_scl_oe = ~r_phase[1];
        w_sda_oe = (r_phase == 2'd3);
      end
      S_STOP: begin
        w_scl_oe = ~r_phase[1];
        w_sda_oe = (r_phase != 2'd3);
      end
      default: begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
      end
    endcase
  end

  assign o_scl_oe      = w_scl_oe;
  assign o_sda_oe      = w_sda_oe;
  assign o_rdata       = r_rdata;
  assign o_rdata_valid = r_rdata_valid;
  assign o_rdata_last  = r_rdata_last;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_nack        = r_nack;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_iic_burst_master.sv
// tb/tb_iic_burst_master.sv - directed bench for iic_burst_master with a bus-level slave model
module tb_iic_burst_master;
  localparam int MAX_BURST = 16;
  localparam int LW        = $clog2(MAX_BURST + 1);
  localparam int BT        = 124;

  logic          clk = 1'b0;
  logic          rst, start, rw;
  logic [6:0]    dev;
  logic [7:0]    regad, wdata;
  logic [LW-1:0] len;
  logic          scl_oe, sda_oe, rdata_valid, rdata_last, busy, done, nack, timeout;
  logic [7:0]    rdata;

  logic s_scl_low = 1'b0, s_sda_low = 1'b0;
  wire  scl_line = ~(scl_oe | s_scl_low);
  wire  sda_line = ~(sda_oe | s_sda_low);

  int   cfg_str_byte = 0, cfg_str_bit = 0, cfg_str_len = 0;
  logic cfg_kill = 1'b0;

  int   vectors = 0, miscompares = 0;

  always #10 clk = ~clk;

  iic_burst_master dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rw(rw), .i_dev_addr(dev),
    .i_reg_addr(regad), .i_wdata(wdata), .i_len(len), .i_scl(scl_line), .i_sda(sda_line),
    .o_scl_oe(scl_oe), .o_sda_oe(sda_oe), .o_rdata(rdata), .o_rdata_valid(rdata_valid),
    .o_rdata_last(rdata_last), .o_busy(busy), .o_done(done), .o_nack(nack), .o_timeout(timeout)
  );

  // Slave at 7-bit address 0x68: ACKs written bytes, returns 0,1,2,... on reads.
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic       s_recv = 1'b0, s_send = 1'b0, s_addr = 1'b0, s_active = 1'b0, s_mack = 1'b0, s_str_on = 1'b0;
  logic [7:0] s_rx = 8'h00, s_tx = 8'h00;
  int         s_bit = 0, s_next = 0, s_sent = 0, s_str_cnt = 0;
  logic [7:0] rx_log [0:63];
  logic       mack_log [0:63];
  int         rx_n = 0, mack_n = 0, stop_n = 0;

  always @(negedge clk) begin
    if (cfg_kill) begin
      s_scl_low = 1'b0; s_sda_low = 1'b0; s_recv = 1'b0; s_send = 1'b0;
      s_active = 1'b0; s_str_on = 1'b0; s_bit = 0;
    end else begin
      if (s_str_on) begin
        if (!scl_oe) s_str_cnt++;
        if (s_str_cnt > cfg_str_len) begin s_str_on = 1'b0; s_scl_low = 1'b0; end
      end
      if (p_scl && scl_line && p_sda && !sda_line) begin
        s_bit = 0; s_recv = 1'b1; s_send = 1'b0; s_addr = 1'b1; s_active = 1'b0;
        s_sda_low = 1'b0; s_next = 0;
      end else if (p_scl && scl_line && !p_sda && sda_line) begin
        stop_n++; s_recv = 1'b0; s_send = 1'b0; s_sda_low = 1'b0;
      end else if (!p_scl && scl_line) begin
        if (s_bit < 8) begin
          if (s_recv) s_rx = {s_rx[6:0], sda_line};
        end else if (s_send) begin
          s_mack = sda_line;
          if (mack_n < 64) mack_log[mack_n] = sda_line;
          mack_n++;
        end
        s_bit++;
      end else if (p_scl && !scl_line) begin
        if (s_bit == 9) begin
          s_bit = 0; s_sda_low = 1'b0;
          if (s_recv && s_addr) begin
            s_addr = 1'b0;
            if (s_active && s_rx[0]) begin
              s_recv = 1'b0; s_send = 1'b1; s_sent = 0; s_tx = 8'(s_next); s_next++;
            end
          end else if (s_send) begin
            if (s_mack) s_send = 1'b0;
            else begin s_sent++; s_tx = 8'(s_next); s_next++; end
          end
        end
        if (s_bit == 8) begin
          if (s_recv) begin
            if (rx_n < 64) rx_log[rx_n] = s_rx;
            rx_n++;
            if (s_addr) s_active = (s_rx[7:1] == 7'h68);
            s_sda_low = s_active;
          end else begin
            s_sda_low = 1'b0;
          end
        end else if (s_send) begin
          s_sda_low = ~s_tx[7 - s_bit];
          if (cfg_str_len != 0 && s_sent == cfg_str_byte && s_bit == cfg_str_bit) begin
            s_str_on = 1'b1; s_scl_low = 1'b1; s_str_cnt = 0;
          end
        end
      end
    end
    p_scl = scl_line;
    p_sda = sda_line;
  end

  logic [7:0] rd_log [0:63];
  logic       rl_log [0:63];
  int         rd_n = 0;
  always @(negedge clk) begin
    if (rdata_valid) begin
      if (rd_n < 64) begin rd_log[rd_n] = rdata; rl_log[rd_n] = rdata_last; end
      rd_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
    vectors++;
    assert (obs >= exp - tol && obs <= exp + tol) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] ra,
                       input logic [7:0] wd, input logic [LW-1:0] l);
    @(negedge clk);
    rw = r; dev = d; regad = ra; wdata = wd; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output logic seen);
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic kill_slave();
    cfg_str_len = 0;
    cfg_kill = 1'b1;
    repeat (2) @(negedge clk);
    cfg_kill = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int   cyc, rb, xb, mb, sb;
    logic seen, bad;
    rst = 1'b1; start = 1'b0; rw = 1'b0; dev = 7'h00; regad = 8'h00; wdata = 8'h00; len = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({busy, done, nack, timeout, rdata_valid, rdata_last, scl_oe, sda_oe, rdata}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // register write 0x68/0x6B <- 0x00
    xb = rx_n; sb = stop_n;
    issue(1'b0, 7'h68, 8'h6B, 8'h00, '0);
    wait_done(10000, cyc, seen);
    chk("wr_done", 32'(seen), 32'd1);
    chk_near("wr_cycles", cyc, 29 * BT, 2);
    chk("wr_flags", 32'({busy, nack, timeout}), 32'd0);
    chk("wr_byte0", 32'(rx_log[xb]), 32'hD0);
    chk("wr_byte1", 32'(rx_log[xb + 1]), 32'h6B);
    chk("wr_byte2", 32'(rx_log[xb + 2]), 32'h00);
    @(negedge clk);
    chk("wr_stop", 32'(stop_n - sb), 32'd1);

    // 14-byte burst read from 0x3B
    xb = rx_n; rb = rd_n; mb = mack_n;
    issue(1'b1, 7'h68, 8'h3B, 8'h00, LW'(14));
    wait_done(30000, cyc, seen);
    chk("rd_done", 32'(seen), 32'd1);
    chk_near("rd_cycles", cyc, 156 * BT, 2);
    chk("rd_flags", 32'({nack, timeout}), 32'd0);
    chk("rd_count", 32'(rd_n - rb), 32'd14);
    chk("rd_addr_w", 32'(rx_log[xb]), 32'hD0);
    chk("rd_reg", 32'(rx_log[xb + 1]), 32'h3B);
    chk("rd_addr_r", 32'(rx_log[xb + 2]), 32'hD1);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("rd_data%0d", i), 32'(rd_log[rb + i]), 32'(i));
      chk($sformatf("rd_last%0d", i), 32'(rl_log[rb + i]), 32'(i == 13));
      chk($sformatf("rd_mack%0d", i), 32'(mack_log[mb + i]), 32'(i == 13));
    end

    // absent device 0x69: write then read
    xb = rx_n; rb = rd_n;
    issue(1'b0, 7'h69, 8'h6B, 8'h00, '0);
    wait_done(10000, cyc, seen);
    chk("abs_wr_done", 32'(seen), 32'd1);
    chk("abs_wr_nack", 32'({nack, timeout, busy}), 32'b100);
    chk_near("abs_wr_cycles", cyc, 11 * BT, 2);
    issue(1'b1, 7'h69, 8'h3B, 8'h00, LW'(4));
    wait_done(10000, cyc, seen);
    chk("abs_rd_done", 32'(seen), 32'd1);
    chk("abs_rd_nack", 32'({nack, timeout, busy}), 32'b100);
    @(negedge clk);
    chk("abs_no_valid", 32'(rd_n - rb), 32'd0);
    chk("abs_bytes", 32'(rx_n - xb), 32'd2);

    // 500-cycle stretch on read bit 3 of the first data byte
    rb = rd_n;
    cfg_str_byte = 0; cfg_str_bit = 3; cfg_str_len = 500;
    issue(1'b1, 7'h68, 8'h10, 8'h00, LW'(2));
    wait_done(20000, cyc, seen);
    chk("str_done", 32'(seen), 32'd1);
    chk_near("str_cycles", cyc, 48 * BT + 500, 2);
    chk("str_flags", 32'({nack, timeout}), 32'd0);
    chk("str_data0", 32'(rd_log[rb]), 32'h00);
    chk("str_data1", 32'({rl_log[rb + 1], rd_log[rb + 1]}), 32'h101);
    cfg_str_len = 0;

    // stretch that never ends -> timeout
    rb = rd_n;
    cfg_str_byte = 0; cfg_str_bit = 3; cfg_str_len = 32'h7FFF_FFFF;
    issue(1'b1, 7'h68, 8'h10, 8'h00, LW'(2));
    wait_done(20000, cyc, seen);
    chk("tmo_done", 32'(seen), 32'd1);
    chk_near("tmo_cycles", cyc, 32 * BT + 31 * 2 + 10000, 2);
    chk("tmo_flags", 32'({timeout, nack, busy}), 32'b100);
    chk("tmo_lines", 32'({scl_oe, sda_oe}), 32'd0);
    chk("tmo_no_valid", 32'(rd_n - rb), 32'd0);
    kill_slave();

    issue(1'b0, 7'h68, 8'h1A, 8'h03, '0);
    wait_done(10000, cyc, seen);
    chk("post_tmo_done", 32'(seen), 32'd1);
    chk("post_tmo_flags", 32'({nack, timeout}), 32'd0);

    // single-byte read boundary
    rb = rd_n; mb = mack_n;
    issue(1'b1, 7'h68, 8'h75, 8'h00, LW'(1));
    wait_done(10000, cyc, seen);
    chk("len1_done", 32'(seen), 32'd1);
    chk_near("len1_cycles", cyc, 39 * BT, 2);
    chk("len1_byte", 32'({rl_log[rb], rd_log[rb]}), 32'h100);
    chk("len1_mnack", 32'({mack_n - mb, 1'b0} | 32'(mack_log[mb])), 32'd3);

    // reset in the middle of a burst
    rb = rd_n;
    issue(1'b1, 7'h68, 8'h3B, 8'h00, LW'(14));
    for (int i = 0; i < 20000 && rd_n < rb + 2; i++) @(negedge clk);
    chk("rst_reached", 32'(rd_n >= rb + 2), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", 32'({busy, done, nack, timeout, rdata_valid, rdata_last, scl_oe, sda_oe, rdata}), 32'd0);
    rst = 1'b0;
    kill_slave();

    // illegal lengths 0 and MAX_BURST+1 must be ignored
    bad = 1'b0;
    issue(1'b1, 7'h68, 8'h3B, 8'h00, LW'(0));
    for (int i = 0; i < 50; i++) begin
      bad = bad | busy | done | scl_oe | sda_oe;
      @(negedge clk);
    end
    chk("len0_ignored", 32'(bad), 32'd0);
    bad = 1'b0;
    issue(1'b1, 7'h68, 8'h3B, 8'h00, LW'(MAX_BURST + 1));
    for (int i = 0; i < 50; i++) begin
      bad = bad | busy | done | scl_oe | sda_oe;
      @(negedge clk);
    end
    chk("len17_ignored", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
